// File: rtl/freecell_move_queue_if.sv
// rtl/freecell_move_queue_if.sv - valid/ready move channel (source/dest code pair)
interface freecell_move_queue_if #(
    parameter int CODE_W = 4
);
    logic              valid;
    logic              ready;
    logic [CODE_W-1:0] src;
    logic [CODE_W-1:0] dst;

    modport master (output valid, output src, output dst, input ready);
    modport slave  (input valid, input src, input dst, output ready);
endinterface

// File: rtl/freecell_move_queue.sv
// rtl/freecell_move_queue.sv - FreeCell move FIFO, engine issue/verdict FSM and statistics
// Optional macro FREECELL_FLUSH_ON_ILLEGAL_EN: illegal verdict or timeout flushes the queue.
module freecell_move_queue #(
    parameter int NUM_COLS  = 8,
    parameter int NUM_CELLS = 4,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    freecell_move_queue_if.slave     host,
    freecell_move_queue_if.master    eng,
    output logic                     bad_code,
    input  logic                     mv_done,
    input  logic                     mv_legal,
    input  logic                     win,
    output logic [CNT_W-1:0]         legal_cnt,
    output logic [CNT_W-1:0]         illegal_cnt,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     done
);
    localparam int HOME   = NUM_COLS + NUM_CELLS;
    localparam int CODE_W = $clog2(HOME + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    localparam logic [CODE_W-1:0] HOME_C   = CODE_W'(HOME);
    localparam logic [LVL_W-1:0]  FULL_C   = LVL_W'(DEPTH);
    localparam logic [TMR_W-1:0]  TMO_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                  state, state_n;
    logic [2*CODE_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [LVL_W-1:0]        count;
    logic [TMR_W-1:0]        timer;
    logic                    rdy_en;
    logic                    mv_valid_q;
    logic [CODE_W-1:0]       src_q, dst_q;
    logic                    bad_in, push, hs, flush;
    logic                    verdict_ok, verdict_bad, tmo;

    assign bad_in = (host.src > HOME_C) || (host.dst > HOME_C) || (host.src == host.dst);
    // rdy_en holds in_ready low through reset and for the first cycle after release
    assign host.ready = rdy_en && (count != FULL_C) && (state != S_DONE);
    assign push       = host.valid && host.ready && !bad_in;

    assign eng.valid = mv_valid_q;
    assign eng.src   = src_q;
    assign eng.dst   = dst_q;
    assign level     = count;
    assign done      = (state == S_DONE);

`ifdef FREECELL_FLUSH_ON_ILLEGAL_EN
    assign flush = win || verdict_bad || tmo;
`else
    assign flush = win;
`endif

    always_comb begin
        state_n     = state;
        hs          = 1'b0;
        verdict_ok  = 1'b0;
        verdict_bad = 1'b0;
        tmo         = 1'b0;
        case (state)
            S_IDLE:  if (count != '0) state_n = S_ISSUE;
            S_ISSUE: if (mv_valid_q && eng.ready) begin
                hs      = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (mv_done) begin
                    verdict_ok  = mv_legal;
                    verdict_bad = !mv_legal;
                    state_n     = S_IDLE;
                end else if (timer == TMO_LAST) begin
                    tmo     = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_DONE;
        endcase
        // a win discards whatever the engine reports in the same cycle
        if (win) begin
            state_n     = S_DONE;
            hs          = 1'b0;
            verdict_ok  = 1'b0;
            verdict_bad = 1'b0;
            tmo         = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            timer       <= '0;
            rdy_en      <= 1'b0;
            mv_valid_q  <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            bad_code    <= 1'b0;
            timeout     <= 1'b0;
            legal_cnt   <= '0;
            illegal_cnt <= '0;
        end else begin
            state    <= state_n;
            rdy_en   <= 1'b1;
            bad_code <= host.valid && host.ready && bad_in;
            timeout  <= tmo;
            timer    <= (state == S_WAIT) ? timer + 1'b1 : '0;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (hs)   rd_ptr <= rd_ptr + 1'b1;
                count <= count + LVL_W'(push) - LVL_W'(hs);
            end

            // engine-facing outputs are registered: head is captured one cycle into ISSUE
            if (state == S_ISSUE && !win && !hs) begin
                mv_valid_q <= 1'b1;
                if (!mv_valid_q) {src_q, dst_q} <= mem[rd_ptr];
            end else begin
                mv_valid_q <= 1'b0;
            end

            if (verdict_ok && legal_cnt != '1)
                legal_cnt <= legal_cnt + 1'b1;
            if ((verdict_bad || tmo) && illegal_cnt != '1)
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= {host.src, host.dst};
    end
endmodule
